// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM pin responder.
// Pin widths, byte-lane ranges, protocol-violation codes and the read-pipe entry.
package sram_pkg;

  localparam int SRAM_DQ_W   = 16;
  localparam int SRAM_ADDR_W = 18;

  // Byte lanes of the 16-bit data bus
  localparam int HI_MSB = 15;
  localparam int HI_LSB = 8;
  localparam int LO_MSB = 7;
  localparam int LO_LSB = 0;

  // Cause of the first protocol violation
  typedef enum logic [1:0] {
    VIOL_NONE      = 2'b00,
    VIOL_WE_OE     = 2'b01,
    VIOL_NULL_MASK = 2'b10,
    VIOL_RANGE     = 2'b11
  } viol_code_e;

  // One slot of the read delay line
  typedef struct packed {
    logic                 valid;
    logic [SRAM_DQ_W-1:0] data;
  } rd_entry_t;

  // Zero the bytes whose active-low mask is deasserted
  function automatic logic [SRAM_DQ_W-1:0] apply_mask(
    input logic [SRAM_DQ_W-1:0] word,
    input logic                 ub_n,
    input logic                 lb_n
  );
    logic [SRAM_DQ_W-1:0] res;
    res = word;
    if (ub_n) res[HI_MSB:HI_LSB] = 8'h00;
    if (lb_n) res[LO_MSB:LO_LSB] = 8'h00;
    return res;
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Control/address pins of the external SRAM as seen between controller and chip.
// The bidirectional data bus is kept out of the interface and travels as a plain
// inout so the tristate resolves at a single net.
interface sram_responder_if #(
  parameter int ADDR_W = sram_pkg::SRAM_ADDR_W
);
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;
  logic              SRAM_WE_N;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;

  // Controller side drives every control pin
  modport master (
    output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );

  // Chip side only observes them
  modport slave (
    input SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );
endinterface

// File: rtl/sram_rd_pipe.sv
// READ_LAT-deep delay line of {valid, data} read entries.
// Advances every clock; synchronous reset drops every in-flight word.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  rd_entry_t in_i,
  output rd_entry_t out_o
);

  rd_entry_t stage_q [READ_LAT];

  // Shift one slot per clock, bubbles included; reset clears all slots
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_i;
      for (int i = 1; i < READ_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_o = stage_q[READ_LAT-1];

endmodule

// File: rtl/sram_responder.sv
// Chip-side model of the external 16-bit asynchronous SRAM, made synchronous to clk.
// Stores words, honours byte masks, returns read data READ_LAT edges after the
// sampling edge and counts accepted reads/writes.
// Optional protocol checker: define SRAM_PROTOCOL_CHECK_EN.
// Valid/ready contract: there is no handshake; every posedge with CE_N=0 is an
// accepted access (write if WE_N=0, else read if OE_N=0), and DQ is driven only
// while a delivered word meets pins that still show a read.
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int MEM_WORDS = 1024,      // power of two, at most 2**ADDR_W
  parameter int READ_LAT  = 1,         // 1..4
  parameter int INIT_ZERO = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_responder_if.slave      bus,
  inout  wire  [SRAM_DQ_W-1:0] SRAM_DQ,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count,
  output logic                 violation,
  output logic [1:0]           viol_code
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [SRAM_DQ_W-1:0] MEM_INIT = (INIT_ZERO != 0) ? '0 : 'x;

  // Storage is given a power-up value only; reset never touches it
  logic [SRAM_DQ_W-1:0] mem [MEM_WORDS] = '{default: MEM_INIT};

  logic [IDX_W-1:0] idx;
  logic             wr_fire;
  logic             rd_fire;
  logic             rd_pins;
  rd_entry_t        pipe_in;
  rd_entry_t        pipe_out;
  logic             dq_oe;
  logic [15:0]      rd_count_q, rd_count_d;
  logic [15:0]      wr_count_q, wr_count_d;

  // Upper address bits alias onto the storage (modulo wrap)
  assign idx = IDX_W'({1'b0, bus.SRAM_ADDR} % (ADDR_W+1)'(MEM_WORDS));

  // Write wins over OE_N; a read needs WE_N high
  assign wr_fire = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
  assign rd_pins = !bus.SRAM_CE_N &&  bus.SRAM_WE_N && !bus.SRAM_OE_N;
  assign rd_fire = rd_pins;

  // Byte-masked write; still committed on a reset edge
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (!bus.SRAM_UB_N) mem[idx][HI_MSB:HI_LSB] <= SRAM_DQ[HI_MSB:HI_LSB];
      if (!bus.SRAM_LB_N) mem[idx][LO_MSB:LO_LSB] <= SRAM_DQ[LO_MSB:LO_LSB];
    end
  end

  // Data is captured at the sampling edge so later writes cannot alter it
  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = rd_fire;
    pipe_in.data  = apply_mask(mem[idx], bus.SRAM_UB_N, bus.SRAM_LB_N);
  end

  sram_rd_pipe #(
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .in_i  (pipe_in),
    .out_o (pipe_out)
  );

  // Drive only while the controller still presents a read, so a turnaround
  // to write never fights the controller's drivers
  assign dq_oe   = pipe_out.valid && rd_pins;
  assign SRAM_DQ = dq_oe ? pipe_out.data : {SRAM_DQ_W{1'bz}};

  // Saturating next-state for the access counters
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (rd_fire && (rd_count_q != 16'hFFFF)) rd_count_d = rd_count_q + 16'd1;
    if (wr_fire && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  // Access counters, held at zero through reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

`ifdef SRAM_PROTOCOL_CHECK_EN
  logic       active;
  logic       out_of_range;
  viol_code_e code_d;
  logic       viol_q;
  viol_code_e code_q;

  assign active       = !bus.SRAM_CE_N && (!bus.SRAM_WE_N || !bus.SRAM_OE_N);
  assign out_of_range = {1'b0, bus.SRAM_ADDR} >= (ADDR_W+1)'(MEM_WORDS);

  // Classify the current edge; earlier rules take priority
  always_comb begin
    code_d = VIOL_NONE;
    if (!bus.SRAM_CE_N && !bus.SRAM_WE_N && !bus.SRAM_OE_N) begin
      code_d = VIOL_WE_OE;
    end else if (active && bus.SRAM_UB_N && bus.SRAM_LB_N) begin
      code_d = VIOL_NULL_MASK;
    end else if (active && out_of_range) begin
      code_d = VIOL_RANGE;
    end
  end

  // Latch only the first offence; sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      viol_q <= 1'b0;
      code_q <= VIOL_NONE;
    end else if (!viol_q && (code_d != VIOL_NONE)) begin
      viol_q <= 1'b1;
      code_q <= code_d;
    end
  end

  assign violation = viol_q;
  assign viol_code = code_q;
`else
  assign violation = 1'b0;
  assign viol_code = VIOL_NONE;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder (READ_LAT=3, MEM_WORDS=1024).
// Undriven DQ floats to 16'hFFFF through a pull-up net.
`timescale 1ns/1ps
module tb_sram_responder;

  localparam int ADDR_W    = 18;
  localparam int MEM_WORDS = 1024;
  localparam int RL        = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_responder_if #(.ADDR_W(ADDR_W)) bus();

  tri1  [15:0] dq;
  logic        tb_dq_oe;
  logic [15:0] tb_dq;
  assign dq = tb_dq_oe ? tb_dq : 16'hzzzz;

  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic        violation;
  logic [1:0]  viol_code;

  sram_responder #(
    .ADDR_W    (ADDR_W),
    .MEM_WORDS (MEM_WORDS),
    .READ_LAT  (RL),
    .INIT_ZERO (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_DQ   (dq),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .violation (violation),
    .viol_code (viol_code)
  );

  // ---------------- model / scoreboard state ----------------
  logic [15:0] model_mem [MEM_WORDS];
  logic [15:0] exp_q [$];
  int          due_q [$];
  int          cyc;
  logic [15:0] exp_rd;
  logic [15:0] exp_wr;
  logic        exp_viol;
  logic [1:0]  exp_code;
  int          n_checks;
  int          n_pass;

  // ---------------- driver ----------------
  // One clock cycle: set pins after a negedge, score DQ, model the next posedge.
  task automatic tick(input logic r, input logic ce_n, input logic we_n,
                      input logic oe_n, input logic ub_n, input logic lb_n,
                      input logic [ADDR_W-1:0] addr, input logic [15:0] wdata);
    logic [15:0] exp_dq;
    logic [15:0] popped;
    logic        rd_pins;
    logic        active;
    int          idx;
    rst            = r;
    bus.SRAM_ADDR  = addr;
    bus.SRAM_CE_N  = ce_n;
    bus.SRAM_WE_N  = we_n;
    bus.SRAM_OE_N  = oe_n;
    bus.SRAM_UB_N  = ub_n;
    bus.SRAM_LB_N  = lb_n;
    tb_dq_oe       = !ce_n && !we_n;
    tb_dq          = wdata;
    #1;
    rd_pins = !ce_n && we_n && !oe_n;
    exp_dq  = 16'hFFFF;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      popped = exp_q.pop_front();
      void'(due_q.pop_front());
      if (rd_pins) exp_dq = popped;
    end
    if (!tb_dq_oe && !r) begin
      n_checks++;
      if (dq !== exp_dq)
        $display("FAIL dq cyc=%0d addr=%h got=%h exp=%h", cyc, addr, dq, exp_dq);
      else
        n_pass++;
    end
    // model of the upcoming sampling edge
    idx = int'(addr) % MEM_WORDS;
    if (!ce_n && !we_n) begin
      if (!ub_n) model_mem[idx][15:8] = wdata[15:8];
      if (!lb_n) model_mem[idx][7:0]  = wdata[7:0];
      if (exp_wr != 16'hFFFF) exp_wr++;
    end else if (rd_pins) begin
      exp_q.push_back({ub_n ? 8'h00 : model_mem[idx][15:8],
                       lb_n ? 8'h00 : model_mem[idx][7:0]});
      due_q.push_back(cyc + RL);
      if (exp_rd != 16'hFFFF) exp_rd++;
    end
`ifdef SRAM_PROTOCOL_CHECK_EN
    active = !ce_n && (!we_n || !oe_n);
    if (!exp_viol) begin
      if (!ce_n && !we_n && !oe_n) begin
        exp_viol = 1'b1; exp_code = 2'b01;
      end else if (active && ub_n && lb_n) begin
        exp_viol = 1'b1; exp_code = 2'b10;
      end else if (active && int'(addr) >= MEM_WORDS) begin
        exp_viol = 1'b1; exp_code = 2'b11;
      end
    end
`else
    active = 1'b0;
`endif
    if (r) begin
      exp_q.delete();
      due_q.delete();
      exp_rd   = '0;
      exp_wr   = '0;
      exp_viol = 1'b0;
      exp_code = 2'b00;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d,
                    input logic ub_n, input logic lb_n);
    tick(1'b0, 1'b0, 1'b0, 1'b1, ub_n, lb_n, a, d);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic ub_n, input logic lb_n);
    tick(1'b0, 1'b0, 1'b1, 1'b0, ub_n, lb_n, a, 16'h0000);
  endtask

  task automatic idle();
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 16'h0000);
  endtask

  // Keep read pins up long enough for everything in flight to be delivered
  task automatic hold_rd(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < RL; i++) rd(a, 1'b0, 1'b0);
    for (int i = 0; i < RL + 1; i++) idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 16'h0000);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 16'h0000);
    idle();
    n_checks++;
    if (rd_count !== 16'd0) $display("FAIL reset_rd_count got=%0d exp=0", rd_count);
    else n_pass++;
    n_checks++;
    if (wr_count !== 16'd0) $display("FAIL reset_wr_count got=%0d exp=0", wr_count);
    else n_pass++;
    n_checks++;
    if (violation !== 1'b0 || viol_code !== 2'b00)
      $display("FAIL reset_viol got=%b/%b exp=0/00", violation, viol_code);
    else n_pass++;
  endtask

  task automatic test_write_read();
    wr(18'd5, 16'hBEEF, 1'b0, 1'b0);
    rd(18'd5, 1'b0, 1'b0);
    n_checks++;
    if (wr_count !== 16'd1 || rd_count !== 16'd1)
      $display("FAIL wr_rd_counts got=%0d/%0d exp=1/1", wr_count, rd_count);
    else n_pass++;
    hold_rd(18'd5);
    rd(18'd4, 1'b0, 1'b0);                 // never written: zero-initialised
    hold_rd(18'd4);
  endtask

  task automatic test_byte_lanes();
    wr(18'd7, 16'h1234, 1'b0, 1'b0);
    wr(18'd7, 16'hAB00, 1'b0, 1'b1);
    rd(18'd7, 1'b0, 1'b0);                 // AB34
    rd(18'd7, 1'b1, 1'b0);                 // 0034
    rd(18'd7, 1'b0, 1'b1);                 // AB00
    hold_rd(18'd7);
  endtask

  task automatic test_wrap();
    wr(18'h00403, 16'h5A5A, 1'b0, 1'b0);
    rd(18'd3, 1'b0, 1'b0);
    rd(18'h3FC03, 1'b0, 1'b0);
    hold_rd(18'd3);
    n_checks++;
    if (violation !== exp_viol || viol_code !== exp_code)
      $display("FAIL wrap_viol got=%b/%b exp=%b/%b", violation, viol_code, exp_viol, exp_code);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    wr(18'd0, 16'h0011, 1'b0, 1'b0);
    wr(18'd1, 16'h0022, 1'b0, 1'b0);
    wr(18'd2, 16'h0033, 1'b0, 1'b0);
    rd(18'd0, 1'b0, 1'b0);
    rd(18'd1, 1'b0, 1'b0);
    rd(18'd2, 1'b0, 1'b0);
    hold_rd(18'd2);
    // write lands while the addr-1 read is still in flight
    rd(18'd1, 1'b0, 1'b0);
    wr(18'd1, 16'hFFFF, 1'b0, 1'b0);
    rd(18'd2, 1'b0, 1'b0);
    rd(18'd2, 1'b0, 1'b0);                 // old 0022 delivered here
    rd(18'd2, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 18'd2, 16'h0000);  // OE_N high
    rd(18'd2, 1'b0, 1'b0);
    idle();
    hold_rd(18'd1);
    n_checks++;
    if (rd_count !== exp_rd || wr_count !== exp_wr)
      $display("FAIL b2b_counts got=%0d/%0d exp=%0d/%0d", rd_count, wr_count, exp_rd, exp_wr);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    rd(18'd5, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'd20, 16'h7777);  // write at reset edge
    n_checks++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0)
      $display("FAIL reset_mid_counts got=%0d/%0d exp=0/0", rd_count, wr_count);
    else n_pass++;
    rd(18'd5, 1'b0, 1'b0);
    rd(18'd5, 1'b0, 1'b0);
    hold_rd(18'd5);
    rd(18'd20, 1'b0, 1'b0);
    hold_rd(18'd20);
  endtask

  task automatic test_protocol();
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 16'h0000);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'd9, 16'h0F0F);
    idle();
    n_checks++;
    if (violation !== exp_viol || viol_code !== exp_code)
      $display("FAIL we_oe_viol got=%b/%b exp=%b/%b", violation, viol_code, exp_viol, exp_code);
    else n_pass++;
    rd(18'd9, 1'b1, 1'b1);                 // null mask
    hold_rd(18'd9);
    n_checks++;
    if (violation !== exp_viol || viol_code !== exp_code)
      $display("FAIL sticky_viol got=%b/%b exp=%b/%b", violation, viol_code, exp_viol, exp_code);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = 16'h0000;
    cyc = 0; exp_rd = '0; exp_wr = '0; exp_viol = 1'b0; exp_code = 2'b00;
    n_checks = 0; n_pass = 0;
    rst = 1'b1; tb_dq_oe = 1'b0; tb_dq = '0;
    bus.SRAM_ADDR = '0; bus.SRAM_CE_N = 1'b1; bus.SRAM_WE_N = 1'b1;
    bus.SRAM_OE_N = 1'b1; bus.SRAM_UB_N = 1'b1; bus.SRAM_LB_N = 1'b1;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_protocol();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL undelivered_reads got=%0d exp=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable responder for the external 16-bit SRAM pin interface (SRAM_DQ/ADDR/UB_N/LB_N/WE_N/CE_N/OE_N), i.e. the chip side of the SRAM controller used by the MEM stage.
- Stands in for the physical SRAM in simulation and in FPGA builds without the chip, so the pipeline, including the pause/freeze path, runs end to end.
- Stores words internally, honours byte masks, returns read data after a configurable latency and keeps access statistics.

Parameters:
- ADDR_W, 18, SRAM address width.
- MEM_WORDS, 1024, internal storage depth in 16-bit words; power of two, max 2^ADDR_W.
- READ_LAT, 1, clock edges from read sample to DQ valid; legal range 1..4.
- INIT_ZERO, 1, 1 = storage initialised to zero at time 0 (initial block); 0 = left X.

Ports:
- clk  in  1  clock, all activity on posedge.
- rst  in  1  synchronous, active-high reset.
- SRAM_DQ  inout  16  data bus; driven only during a qualified read, else high-Z.
- SRAM_ADDR  in  ADDR_W  word address.
- SRAM_UB_N  in  1  high-byte mask, active low.
- SRAM_LB_N  in  1  low-byte mask, active low.
- SRAM_WE_N  in  1  write enable, active low.
- SRAM_CE_N  in  1  chip enable, active low.
- SRAM_OE_N  in  1  output enable, active low.
- rd_count  out  16  number of read cycles accepted, saturating.
- wr_count  out  16  number of write cycles accepted, saturating.
- violation  out  1  sticky protocol-violation flag.
- viol_code  out  2  cause of first violation.

Behaviour:
- Reset is synchronous active-high on rst; clock is clk.
- Reset values:
  - rd_count=0, wr_count=0, violation=0, viol_code=0.
  - All read-pipe valid bits cleared; DQ released to high-Z from the reset edge.
  - Storage is NOT cleared by reset.
- Index: idx = SRAM_ADDR mod MEM_WORDS; upper address bits are ignored (aliasing wrap).
- Write cycle, sampled at a posedge when CE_N=0 and WE_N=0:
  - UB_N=0 writes DQ[15:8]; LB_N=0 writes DQ[7:0].
  - wr_count increments, saturating at 16'hFFFF.
  - Write takes priority over OE_N; DQ is never driven during a write.
- Read cycle, sampled at a posedge when CE_N=0, WE_N=1 and OE_N=0:
  - mem[idx] is captured at that sampling edge (read-at-sample), so a later write does not alter data already in flight.
  - Masked bytes (mask_N=1) are replaced with 8'h00.
  - rd_count increments, saturating at 16'hFFFF.
- Read pipe:
  - READ_LAT-deep shift of {valid, data}; advances every clock, and CE_N=1 cycles enter as bubbles.
  - DQ is driven with the pipe output when output valid=1 AND the current pins show CE_N=0, WE_N=1, OE_N=0 (combinational gate avoids contention on controller turnaround). Otherwise DQ is high-Z.
  - Back-to-back reads deliver one word per cycle.
- Read-after-write: a read sampled at the edge after a write to the same idx returns the new data.
- CE_N=1: no write, no read, no count change.
- Reset mid-operation: in-flight reads are discarded and no DQ drive follows. A write sampled at the reset edge is still committed to storage; counters are held at 0.

Optional Feature:
- Macro: SRAM_PROTOCOL_CHECK_EN.
- With the macro, violation is set and viol_code latched on the first offending sampled edge, sticky until rst:
  - 01: CE_N=0 with WE_N=0 and OE_N=0.
  - 10: active access (CE_N=0, WE_N=0 or OE_N=0) with UB_N=LB_N=1.
  - 11: active access with SRAM_ADDR >= MEM_WORDS.
  - Access semantics are unchanged.
- Without the macro: violation=0 and viol_code=0 constantly; the ports remain present.

Decomposition:
- Package sram_pkg:
  - Constants SRAM_DQ_W=16, SRAM_ADDR_W=18.
  - Byte-lane ranges.
  - VIOL_NONE/VIOL_WE_OE/VIOL_NULL_MASK/VIOL_RANGE 2-bit codes.
  - Typedef for the read-pipe entry {valid, data[15:0]}.
- One sub-module, sram_rd_pipe: parameterised READ_LAT delay line with synchronous clear.

Test Plan:
- Reset, then write 16'hBEEF to addr 5 with UB_N=LB_N=0, then read addr 5 with READ_LAT=1 -> DQ=16'hBEEF in the cycle after the sample edge; wr_count=1, rd_count=1.
- Byte lanes: write 16'h1234 to addr 7, then 16'hAB00 with UB_N=0 and LB_N=1 -> full read gives 16'hAB34; read with UB_N=1, LB_N=0 gives 16'h0034.
- Wrap, MEM_WORDS=1024: write 16'h5A5A at addr 18'h00403 -> read of addr 3 returns 16'h5A5A.
- READ_LAT=3, back-to-back reads of addr 0,1,2 (holding 16'h0011/0022/0033):
  - DQ shows 0011, 0022, 0033 on consecutive cycles starting 3 edges after the first sample.
  - A write of 16'hFFFF to addr 1 after its sample still delivers 0022.
  - DQ is high-Z when OE_N is deasserted.
- Read of addr 5 in flight with READ_LAT=2, rst asserted one edge later -> DQ high-Z after the reset edge; counters 0; re-read of addr 5 returns 16'hBEEF.
- With SRAM_PROTOCOL_CHECK_EN: CE_N=WE_N=OE_N=0 with DQ=16'h0F0F at addr 9 -> violation=1, viol_code=01, mem[9]=16'h0F0F, DQ never driven. A later null-mask access leaves viol_code=01.
